sliding_window_padded: RTL and testbench

SLIDING_WINDOW_PADDED -- requirements
Module: sliding_window_padded

---
 rtl/sliding_window_padded.sv | 137 +++++++++++++
 tb/tb_sliding_window_padded.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_padded.sv
// Sliding window generator over a row-major pixel stream, with optional
// "same" border padding. The block scans a virtual frame that includes the
// padding ring. Padding positions are synthesized internally. Each window is
// emitted through a single output register with valid/ready handshaking.
module sliding_window_padded #(
  parameter int IN_HEIGHT     = 600,
  parameter int IN_WIDTH      = 800,
  parameter int WINDOW_HEIGHT = 3,
  parameter int WINDOW_WIDTH  = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNELS      = 1,
  parameter int PADDING       = 0,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                                                      clock_i,
  input  logic                                                      reset_i,
  input  logic                                                      slave_valid_i,
  output logic                                                      slave_ready_o,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                            slave_data_i,
  output logic                                                      master_valid_o,
  input  logic                                                      master_ready_i,
  output logic [WINDOW_HEIGHT*WINDOW_WIDTH*CHANNELS*DATA_WIDTH-1:0] master_data_o,
  output logic                                                      master_last_o
);
  localparam int WH    = WINDOW_HEIGHT;
  localparam int WW    = WINDOW_WIDTH;
  localparam int PH    = PADDING * (WH - 1) / 2;
  localparam int PW    = PADDING * (WW - 1) / 2;
  localparam int VH    = IN_HEIGHT + 2 * PH;
  localparam int VW    = IN_WIDTH + 2 * PW;
  localparam int PIX_W = CHANNELS * DATA_WIDTH;
  localparam int NLB   = WH - 1;
  localparam int RW    = $clog2(VH);
  localparam int CW    = $clog2(VW);
  localparam int LBW   = (NLB > 1) ? $clog2(NLB) : 1;
  localparam int WIN_W = WH * WW * PIX_W;

  // Centered padding is only defined for odd window dimensions.
  if (PADDING == 1 && ((WH % 2) == 0 || (WW % 2) == 0)) begin : g_bad_pad
    $error("sliding_window_padded: PADDING=1 needs odd window dimensions");
  end

  logic [RW-1:0]  vrow;
  logic [CW-1:0]  vcol;
  logic [LBW-1:0] brow;   // vrow mod NLB, tracked incrementally
  int             vr, vc;
  logic           is_real, free, adv, emit, row_end, frame_end;
  logic [PIX_W-1:0] pix;

  assign vr        = int'(vrow);
  assign vc        = int'(vcol);
  assign is_real   = (vr >= PH) && (vr < PH + IN_HEIGHT) &&
                     (vc >= PW) && (vc < PW + IN_WIDTH);
  assign free      = !master_valid_o || master_ready_i;
  assign adv       = free && (!is_real || slave_valid_i);
  assign emit      = adv && (vr >= WH - 1) && (vc >= WW - 1);
  assign row_end   = (vcol == CW'(VW - 1));
  assign frame_end = row_end && (vrow == RW'(VH - 1));
  assign slave_ready_o = !reset_i && is_real && free;
  assign pix       = is_real ? slave_data_i : {CHANNELS{PAD_VALUE}};

  // Line buffers: buffer brow holds the current row; the other buffers hold
  // the most recent previous rows. The oldest row sits in the buffer that is
  // about to be overwritten, so it is read before the write at the edge.
  logic [PIX_W-1:0] lb [NLB][VW];
  logic [WH-1:0][PIX_W-1:0] col;

  for (genvar r = 0; r < NLB; r++) begin : g_col
    logic [LBW:0] s;
    assign s = {1'b0, brow} + (LBW+1)'(r);
    assign col[r] = lb[(s >= (LBW+1)'(NLB)) ? LBW'(s - (LBW+1)'(NLB)) : s[LBW-1:0]][vcol];
  end
  assign col[WH-1] = pix;

  // Store every advanced position into the line buffer of its row.
  always_ff @(posedge clock_i) begin
    if (adv) lb[brow][vcol] <= pix;
  end

  // Column shift register: holds the WW-1 columns left of the current position.
  logic [WH-1:0][WW-2:0][PIX_W-1:0] sr;
  always_ff @(posedge clock_i) begin
    if (adv) begin
      for (int r = 0; r < WH; r++) begin
        for (int c = 0; c < WW - 2; c++) sr[r][c] <= sr[r][c+1];
        sr[r][WW-2] <= col[r];
      end
    end
  end

  // Window assembly: the rightmost column is live, the rest comes from sr.
  logic [WIN_W-1:0] win;
  always_comb begin
    win = '0;
    for (int r = 0; r < WH; r++) begin
      for (int c = 0; c < WW - 1; c++) win[(r*WW + c)*PIX_W +: PIX_W] = sr[r][c];
      win[(r*WW + WW - 1)*PIX_W +: PIX_W] = col[r];
    end
  end

  // Scan counters and output handshake state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      vrow           <= '0;
      vcol           <= '0;
      brow           <= '0;
      master_valid_o <= 1'b0;
      master_last_o  <= 1'b0;
    end else begin
      if (adv) begin
        if (row_end) begin
          vcol <= '0;
          if (frame_end) begin
            vrow <= '0;
            brow <= '0;
          end else begin
            vrow <= vrow + RW'(1);
            brow <= (brow == LBW'(NLB - 1)) ? '0 : brow + LBW'(1);
          end
        end else begin
          vcol <= vcol + CW'(1);
        end
      end
      if (emit) begin
        master_valid_o <= 1'b1;
        master_last_o  <= frame_end;
      end else if (master_ready_i) begin
        master_valid_o <= 1'b0;
      end
    end
  end

  // Window payload only changes on a load, so it stays put while stalled.
  always_ff @(posedge clock_i) begin
    if (emit) master_data_o <= win;
  end
endmodule

// File: tb/tb_sliding_window_padded.sv
// Directed bench for sliding_window_padded on a 4x4 ramp with a 3x3 window:
// u0 = no padding, u1 = same padding (pad 0xFF), u2 = no padding, 2 channels.
module tb_sliding_window_padded;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mr;
  logic sv [3];
  logic srdy [3];
  logic mv [3];
  logic ml [3];
  logic [7:0]   d0, d1;
  logic [15:0]  d2;
  logic [71:0]  md0, md1;
  logic [143:0] md2;
  logic [143:0] mdx [3];

  assign mdx[0] = {72'b0, md0};
  assign mdx[1] = {72'b0, md1};
  assign mdx[2] = md2;

  sliding_window_padded #(.IN_HEIGHT(4), .IN_WIDTH(4), .WINDOW_HEIGHT(3), .WINDOW_WIDTH(3),
    .DATA_WIDTH(8), .CHANNELS(1), .PADDING(0), .PAD_VALUE(8'h00)) u0 (
    .clock_i(clk), .reset_i(rst), .slave_valid_i(sv[0]), .slave_ready_o(srdy[0]),
    .slave_data_i(d0), .master_valid_o(mv[0]), .master_ready_i(mr),
    .master_data_o(md0), .master_last_o(ml[0]));

  sliding_window_padded #(.IN_HEIGHT(4), .IN_WIDTH(4), .WINDOW_HEIGHT(3), .WINDOW_WIDTH(3),
    .DATA_WIDTH(8), .CHANNELS(1), .PADDING(1), .PAD_VALUE(8'hFF)) u1 (
    .clock_i(clk), .reset_i(rst), .slave_valid_i(sv[1]), .slave_ready_o(srdy[1]),
    .slave_data_i(d1), .master_valid_o(mv[1]), .master_ready_i(mr),
    .master_data_o(md1), .master_last_o(ml[1]));

  sliding_window_padded #(.IN_HEIGHT(4), .IN_WIDTH(4), .WINDOW_HEIGHT(3), .WINDOW_WIDTH(3),
    .DATA_WIDTH(8), .CHANNELS(2), .PADDING(0), .PAD_VALUE(8'h00)) u2 (
    .clock_i(clk), .reset_i(rst), .slave_valid_i(sv[2]), .slave_ready_o(srdy[2]),
    .slave_data_i(d2), .master_valid_o(mv[2]), .master_ready_i(mr),
    .master_data_o(md2), .master_last_o(ml[2]));

  int n_tests = 0, n_fail = 0;
  int pix_cnt [3];
  int widx [3];
  int nwin [3];
  int feed_lim;
  bit prev_stall [3];
  logic [143:0] prev_data [3];
  logic prev_last [3];
  bit after_rst;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nwin_frame(input int d);
    return (d == 1) ? 16 : 4;
  endfunction

  // Reference window: direct 2-D indexing into the ramp frame.
  function automatic logic [143:0] ref_win(input int d, input int idx);
    logic [143:0] w;
    logic [7:0] e;
    int ch, nw, wr, wc, pr, pc;
    w  = '0;
    ch = (d == 2) ? 2 : 1;
    nw = (d == 1) ? 4 : 2;
    wr = idx / nw;
    wc = idx % nw;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        pr = (d == 1) ? wr + r - 1 : wr + r;
        pc = (d == 1) ? wc + c - 1 : wc + c;
        if (pr < 0 || pr > 3 || pc < 0 || pc > 3) e = 8'hFF;
        else e = 8'(pr * 4 + pc);
        for (int k = 0; k < ch; k++)
          w[((r*3 + c)*ch + k)*8 +: 8] = (k == 1) ? e + 8'd100 : e;
      end
    return w;
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, account transfers.
  task automatic step(input bit rnd, input bit do_rst);
    int idx;
    @(negedge clk);
    rst = do_rst;
    mr  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int d = 0; d < 3; d++)
      sv[d] = !do_rst && (pix_cnt[d] < feed_lim) && (!rnd || $urandom_range(0, 1) == 1);
    d0 = 8'(pix_cnt[0] % 16);
    d1 = 8'(pix_cnt[1] % 16);
    d2 = {8'(pix_cnt[2] % 16 + 100), 8'(pix_cnt[2] % 16)};
    #1;
    for (int d = 0; d < 3; d++) begin
      if (after_rst)
        chk($sformatf("post_rst_valid u%0d", d), 144'(mv[d]), 144'(0));
      if (do_rst) begin
        chk($sformatf("rst_ready u%0d", d), 144'(srdy[d]), 144'(0));
        prev_stall[d] = 1'b0;
        continue;
      end
      if (prev_stall[d]) begin
        chk($sformatf("stall_valid u%0d", d), 144'(mv[d]), 144'(1));
        chk($sformatf("stall_data u%0d", d), mdx[d], prev_data[d]);
        chk($sformatf("stall_last u%0d", d), 144'(ml[d]), 144'(prev_last[d]));
      end
      if (mv[d] && mr) begin
        idx = widx[d];
        chk($sformatf("win u%0d #%0d", d, idx), mdx[d], ref_win(d, idx));
        chk($sformatf("last u%0d #%0d", d, idx), 144'(ml[d]),
            144'(idx == nwin_frame(d) - 1));
        if (d == 0 && idx == 0)
          chk("u0 first", mdx[0], 144'({8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}));
        if (d == 0 && idx == 3)
          chk("u0 final", mdx[0], 144'({8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}));
        if (d == 1 && idx == 0)
          chk("u1 first", mdx[1], 144'({8'd5, 8'd4, 8'hFF, 8'd1, 8'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF}));
        if (d == 1 && idx == 15)
          chk("u1 final", mdx[1], 144'({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd15, 8'd14, 8'hFF, 8'd11, 8'd10}));
        widx[d] = (idx + 1) % nwin_frame(d);
        nwin[d]++;
      end
      prev_stall[d] = mv[d] && !mr;
      prev_data[d]  = mdx[d];
      prev_last[d]  = ml[d];
      if (sv[d] && srdy[d]) pix_cnt[d]++;
    end
    after_rst = 1'b0;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) begin
      pix_cnt[d] = 0; widx[d] = 0; nwin[d] = 0; prev_stall[d] = 1'b0;
    end
  endtask

  task automatic chk_counts(input string tag, input int frames);
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s nwin u%0d", tag, d), 144'(nwin[d]), 144'(frames * nwin_frame(d)));
  endtask

  initial begin
    rst = 1'b1; mr = 1'b0; d0 = '0; d1 = '0; d2 = '0;
    for (int d = 0; d < 3; d++) sv[d] = 1'b0;
    after_rst = 1'b0;
    feed_lim = 0;
    clear_counts();

    // Reset state
    repeat (3) step(1'b0, 1'b1);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid u%0d", d), 144'(mv[d]), 144'(0));
      chk($sformatf("rst_last u%0d", d), 144'(ml[d]), 144'(0));
    end
    clear_counts();

    // One frame, always ready; padded DUT must flush trailing windows alone
    feed_lim = 16;
    repeat (80) step(1'b0, 1'b0);
    chk_counts("frame1", 1);
    for (int d = 0; d < 3; d++)
      chk($sformatf("frame1 pix u%0d", d), 144'(pix_cnt[d]), 144'(16));

    // Three more frames with random backpressure and input gaps
    feed_lim = 64;
    repeat (1500) step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);
    chk_counts("random", 4);

    // Mid-frame reset after 7 pixels of a new frame on u0
    feed_lim = 71;
    for (int i = 0; i < 60 && pix_cnt[0] < 71; i++) step(1'b0, 1'b0);
    chk("pre_rst pix u0", 144'(pix_cnt[0]), 144'(71));
    step(1'b0, 1'b1);
    clear_counts();
    after_rst = 1'b1;
    feed_lim = 16;
    repeat (80) step(1'b0, 1'b0);
    chk_counts("post_rst", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
